// File: rtl/tetris_score_pkg.sv
// Shared definitions for the Tetris scoring stage: FSM states, ceilings and
// the row-count to base-points table.
package tetris_score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  localparam int unsigned SCORE_MAX = 9999;
  localparam int unsigned LINES_MAX = 999;
  localparam int unsigned LEVEL_MAX = 9;

  // Base points for a clear of 1..4 rows; anything else scores nothing.
  function automatic logic [3:0] base_points(input logic [2:0] rows);
    case (rows)
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      3'd4:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/score_sat_add.sv
// Combinational saturating adder: 14-bit a plus 4-bit b, clamped at CEIL.
module score_sat_add #(
  parameter int unsigned CEIL = 9999
) (
  input  logic [13:0] a_i,
  input  logic [3:0]  b_i,
  output logic [13:0] sum_o
);

  // One extra bit of headroom so the raw sum can never wrap before the clamp.
  logic [14:0] raw_sum;

  // Add, then clamp to the ceiling.
  always_comb begin
    raw_sum = {1'b0, a_i} + {11'd0, b_i};
    sum_o   = (raw_sum > 15'(CEIL)) ? 14'(CEIL) : raw_sum[13:0];
  end

endmodule

// File: rtl/score_keeper.sv
// Tetris scoring stage: accepts line-clear events and drop bonuses, keeps a
// saturating score, line total, level and session high score.
module score_keeper #(
  parameter int unsigned SCORE_MAX       = tetris_score_pkg::SCORE_MAX,
  parameter int unsigned LINES_MAX       = tetris_score_pkg::LINES_MAX,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned LEVEL_MAX       = tetris_score_pkg::LEVEL_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        clear_valid,
  input  logic [2:0]  clear_lines,
  output logic        clear_ready,
  input  logic        drop_bonus,
  output logic [13:0] score,
  output logic [13:0] high_score,
  output logic [9:0]  lines,
  output logic [3:0]  level,
  output logic        busy
);
  import tetris_score_pkg::*;

  state_e      state_q, state_d;
  logic [13:0] score_q, score_d;
  logic [13:0] high_q, high_d;
  logic [9:0]  lines_q, lines_d;
  logic [3:0]  level_q, level_d;
  logic [3:0]  base_q, base_d;
  logic [3:0]  reps_q, reps_d;
  logic [2:0]  rows_q, rows_d;

  logic        handshake;
  logic [3:0]  event_base;
  logic [3:0]  add_b;
  logic [13:0] add_sum;
  logic [10:0] lines_raw;
  logic [9:0]  lines_new;

  // Level from the line total via a compare chain against multiples of
  // LINES_PER_LEVEL, capped at LEVEL_MAX.
  function automatic logic [3:0] level_of(input logic [9:0] l);
    logic [3:0] lv;
    lv = '0;
    for (int unsigned k = 1; k <= LEVEL_MAX; k++) begin
      if (32'(l) >= k * LINES_PER_LEVEL) lv = 4'(k);
    end
    return lv;
  endfunction

  assign clear_ready = (state_q == ST_IDLE);
  assign busy        = ~clear_ready;
  assign handshake   = clear_valid & clear_ready;
  assign event_base  = base_points(clear_lines);

  // The single adder serves both the multiply-by-repeated-addition and the
  // drop bonus; they can never be active in the same cycle.
  assign add_b = (state_q == ST_ACCUM) ? base_q : 4'd1;

  score_sat_add #(.CEIL(SCORE_MAX)) u_add (
    .a_i   (score_q),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  // Saturating line total used by the UPDATE state.
  always_comb begin
    lines_raw = {1'b0, lines_q} + {8'd0, rows_q};
    lines_new = (lines_raw > 11'(LINES_MAX)) ? 10'(LINES_MAX) : lines_raw[9:0];
  end

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    lines_d = lines_q;
    level_d = level_q;
    base_d  = base_q;
    reps_d  = reps_q;
    rows_d  = rows_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          // Illegal row counts complete the handshake but are discarded.
          if (event_base != 4'd0) begin
            base_d  = event_base;
            reps_d  = level_q + 4'd1;
            rows_d  = clear_lines;
            state_d = ST_ACCUM;
          end
        end else if (drop_bonus) begin
          score_d = add_sum;
          high_d  = (add_sum > high_q) ? add_sum : high_q;
        end
      end
      ST_ACCUM: begin
        score_d = add_sum;
        reps_d  = reps_q - 4'd1;
        if (reps_q == 4'd1) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        lines_d = lines_new;
        level_d = level_of(lines_new);
        high_d  = (score_q > high_q) ? score_q : high_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new game wipes the round and any award still being accumulated.
    if (new_game) begin
      state_d = ST_IDLE;
      score_d = '0;
      lines_d = '0;
      level_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values, independent of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      high_q  <= '0;
      lines_q <= '0;
      level_q <= '0;
      base_q  <= '0;
      reps_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      lines_q <= lines_d;
      level_q <= level_d;
      base_q  <= base_d;
      reps_q  <= reps_d;
      rows_q  <= rows_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign lines      = lines_q;
  assign level      = level_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper with a scoreboard of expected states.
module tb_score_keeper;

  localparam int SMAX = 9999;
  localparam int LMAX = 999;

  logic        clk = 1'b0;
  logic        reset, new_game, clear_valid, drop_bonus;
  logic [2:0]  clear_lines;
  logic        clear_ready, busy;
  logic [13:0] score, high_score;
  logic [9:0]  lines;
  logic [3:0]  level;

  score_keeper dut (
    .clk         (clk),
    .reset       (reset),
    .new_game    (new_game),
    .clear_valid (clear_valid),
    .clear_lines (clear_lines),
    .clear_ready (clear_ready),
    .drop_bonus  (drop_bonus),
    .score       (score),
    .high_score  (high_score),
    .lines       (lines),
    .level       (level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int lines;
    int level;
    int high;
    int busy_cycles;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  int m_score, m_lines, m_level, m_high;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int model_base(input int rows);
    case (rows)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic push_model(input int busy_cycles);
    exp_t e;
    e.score = m_score;
    e.lines = m_lines;
    e.level = m_level;
    e.high  = m_high;
    e.busy_cycles = busy_cycles;
    exp_q.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_score"}, int'(score), e.score);
    check({tag, "_lines"}, int'(lines), e.lines);
    check({tag, "_level"}, int'(level), e.level);
    check({tag, "_high"},  int'(high_score), e.high);
    check({tag, "_ready"}, int'(clear_ready), 1);
    check({tag, "_busy"},  int'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_score = 0; m_lines = 0; m_level = 0; m_high = 0;
    push_model(0);
    pop_compare("reset");
  endtask

  // drop_mode: 0 none, 1 pulse with the handshake, 2 pulse in first ACCUM cycle.
  task automatic do_clear(input string tag, input int rows, input int drop_mode);
    int base, reps, start, n;
    exp_t e;
    base  = model_base(rows);
    reps  = m_level + 1;
    start = m_score;
    if (base != 0) begin
      m_score = min2(start + base * reps, SMAX);
      m_lines = min2(m_lines + rows, LMAX);
      m_level = min2(m_lines / 10, 9);
      if (m_score > m_high) m_high = m_score;
      push_model(reps + 1);
    end else begin
      push_model(0);
    end

    clear_valid = 1'b1;
    clear_lines = 3'(rows);
    drop_bonus  = (drop_mode == 1);
    tick();
    clear_valid = 1'b0;
    clear_lines = 3'd0;
    drop_bonus  = 1'b0;

    n = 0;
    while (!clear_ready && n < 64) begin
      n++;
      if (n <= reps)
        check({tag, "_accum_score"}, int'(score), min2(start + base * (n - 1), SMAX));
      drop_bonus = (drop_mode == 2 && n == 1);
      tick();
      drop_bonus = 1'b0;
    end
    e = exp_q[0];
    check({tag, "_busy_cycles"}, n, e.busy_cycles);
    pop_compare(tag);
  endtask

  task automatic do_drop(input string tag);
    m_score = min2(m_score + 1, SMAX);
    if (m_score > m_high) m_high = m_score;
    push_model(0);
    drop_bonus = 1'b1;
    tick();
    drop_bonus = 1'b0;
    pop_compare(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; new_game = 1'b0; clear_valid = 1'b0;
    clear_lines = 3'd0; drop_bonus = 1'b0;
    tick();
    do_reset();

    // Level 0, four rows: 8 points, two busy cycles.
    do_clear("clr4_l0", 4, 0);
    check("clr4_l0_score_abs", int'(score), 8);

    // Reach 10 lines, then level 1 triple: +5 then +5.
    do_clear("clr4_b", 4, 0);
    do_clear("clr2", 2, 0);
    check("level1_reached", int'(level), 1);
    do_clear("clr3_l1", 3, 0);

    // Illegal row counts complete in one cycle with no change.
    do_clear("clr0", 0, 0);
    do_clear("clr5", 5, 0);

    // Drop bonus: dropped in ACCUM and with a handshake, counted in IDLE.
    do_clear("drop_accum", 1, 2);
    do_clear("drop_hs", 2, 1);
    do_drop("drop_idle");

    // Climb to level 9, then approach the ceiling.
    while (m_level < 9) do_clear("climb", 4, 0);
    while (m_score + 80 <= 9995) do_clear("fill", 4, 0);
    while (m_score < 9995) do_drop("pad");
    check("pre_sat_score", int'(score), 9995);
    do_clear("sat_clr", 4, 0);
    check("sat_score_abs", int'(score), 9999);
    check("sat_high_abs", int'(high_score), 9999);
    do_drop("sat_drop");

    // New game mid-ACCUM keeps the high score; reset clears it.
    do_reset();
    for (int i = 0; i < 37; i++) do_drop("to37");
    clear_valid = 1'b1;
    clear_lines = 3'd4;
    tick();
    clear_valid = 1'b0;
    clear_lines = 3'd0;
    check("ng_in_accum", int'(clear_ready), 0);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_score = 0; m_lines = 0; m_level = 0;
    push_model(0);
    pop_compare("new_game");
    check("ng_high_abs", int'(high_score), 37);
    do_reset();

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Tetris scoring stage that sits directly upstream of the seven-segment display driver. It consumes line-clear events from the playfield logic and drop-bonus pulses, and maintains a saturating decimal-range score. It also tracks the cleared-line total, the derived level and a session high score. `score` feeds the display's 14-bit `num` input, so it never exceeds 9999.

## Interface
Parameters:
- `SCORE_MAX`, 9999: saturation ceiling for `score` and `high_score`.
- `LINES_MAX`, 999: saturation ceiling for `lines`.
- `LINES_PER_LEVEL`, 10: lines needed per level step.
- `LEVEL_MAX`, 9: level cap.

Ports:
- `clk`  in  1: system clock; one clock domain.
- `reset`  in  1: synchronous, active-high; clears all state, including `high_score`.
- `new_game`  in  1: one-cycle pulse; clears `score`, `lines` and `level`; keeps `high_score`.
- `clear_valid`  in  1: a line-clear event is offered.
- `clear_lines`  in  3: rows cleared by the event; legal values are 1–4.
- `clear_ready`  out  1: block can accept an event.
- `drop_bonus`  in  1: one-cycle pulse; adds 1 point.
- `score`  out  14: current score, 0..SCORE_MAX.
- `high_score`  out  14: best score since `reset`.
- `lines`  out  10: total lines cleared, 0..LINES_MAX.
- `level`  out  4: current level, 0..LEVEL_MAX.
- `busy`  out  1: equals `!clear_ready`.

## Operation
- Reset values: `score`=0, `high_score`=0, `lines`=0, `level`=0, FSM in IDLE, `clear_ready`=1.
- Control priority: `reset` > `new_game` > everything else.
  - `new_game` forces the FSM to IDLE.
  - It discards any in-flight award.
- Base points for 1/2/3/4 cleared rows: 1/3/5/8.
- Award for an event: base × (`level`+1), using the level at the moment the event is accepted.
- The multiply is done by repeated addition.
- FSM states:
  - IDLE:
    - `clear_ready`=1.
    - A handshake (`clear_valid` && `clear_ready`) with `clear_lines` in 1..4 latches `base`, `reps`=`level`+1 and `clear_lines`, then moves to ACCUM.
    - A handshake with `clear_lines` of 0 or 5..7 completes but is discarded; the FSM stays in IDLE.
  - ACCUM:
    - Each cycle: `score` = min(`score`+`base`, SCORE_MAX), and `reps` decrements.
    - After the cycle in which `reps` reaches 1, the FSM moves to UPDATE.
  - UPDATE:
    - `lines` = min(`lines`+`clear_lines`, LINES_MAX).
    - `level` = min(new `lines` / LINES_PER_LEVEL, LEVEL_MAX).
    - `high_score` = max(`high_score`, `score`).
    - The FSM then moves to IDLE.
- `drop_bonus`:
  - Applied only in IDLE, and only when no valid clear handshake occurs in the same cycle: `score` = min(`score`+1, SCORE_MAX), and `high_score` is updated in the same cycle.
  - Pulses arriving in ACCUM or UPDATE, or coinciding with a handshake, are dropped.
- Saturation arithmetic uses 15-bit internal sums compared against SCORE_MAX, so the result can never wrap.

## Timing
- Event accepted in cycle T:
  - ACCUM occupies cycles T+1..T+L, where L = `level`+1.
  - UPDATE occurs in cycle T+L+1.
  - `clear_ready` is low from T+1 through T+L+1, and high again in T+L+2.
- `score` reaches its final value at the edge ending cycle T+L.
- `lines`, `level` and `high_score` update at the edge ending cycle T+L+1.
- Throughput: at most one event per L+2 cycles.
- `drop_bonus` effect is visible one edge after the pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs, except `clear_ready`/`busy` decoded from the state register.
- `reset` or `new_game` asserted in any state takes effect at the next edge.
  - Partial ACCUM additions already applied are overwritten by zero.

## Structure
- Shared package `tetris_score_pkg` holds:
  - the FSM state enum (IDLE, ACCUM, UPDATE);
  - the constants SCORE_MAX, LINES_MAX and LEVEL_MAX;
  - a base-points lookup function (3-bit row count → 4-bit points, 0 for illegal values).
- One sub-module, `score_sat_add`: combinational saturating adder, 14-bit a + 4-bit b, with ceiling parameter. It is instantiated for the ACCUM/drop path.
- Level computation is a compare chain against multiples of LINES_PER_LEVEL; no divider is used.

## Test plan
- Reset → `score`=0, `high_score`=0, `lines`=0, `level`=0, `clear_ready`=1 on the first cycle after release.
- Level 0, offer `clear_lines`=4 → accepted; `clear_ready` low for 2 cycles; `score`=8, `lines`=4, `high_score`=8, `level`=0.
- Clears of 4, 4, 2 rows (`lines`=10) → `level`=1. Then clear 3 rows → two ACCUM cycles, `score` grows by 5 then 5 (total +10); `clear_ready` low for 3 cycles.
- Drive `score` to 9995 at `level`=9, then clear 4 rows (award 80) → `score`=9999, `high_score`=9999; a further `drop_bonus` leaves 9999.
- With `score`=37, pulse `new_game` mid-ACCUM → `score`, `lines` and `level` become 0, `high_score` stays 37, FSM is in IDLE. Then assert `reset` → `high_score`=0.
- Offer `clear_lines`=0 and 5 → each is accepted in one cycle with no state change. `drop_bonus` during ACCUM is ignored; `drop_bonus` in IDLE increments `score` by 1.
